// File: rtl/key_pulse_gen_if.sv
// Key conditioner bus: raw active-low buttons in, debounced levels and
// one-cycle active-low press pulses out.
interface key_pulse_gen_if #(
  parameter int NUM_KEYS = 3
);
  logic [NUM_KEYS-1:0] key_in_n;
  logic [NUM_KEYS-1:0] key_pulse_n;
  logic [NUM_KEYS-1:0] key_level;

  modport master (
    output key_in_n,
    input  key_pulse_n,
    input  key_level
  );

  modport slave (
    input  key_in_n,
    output key_pulse_n,
    output key_level
  );
endinterface

// File: rtl/key_pulse_gen.sv
// Per-key synchroniser, debouncer and press-pulse generator with optional
// auto-repeat while an adjust key is held.
module key_pulse_gen #(
  parameter int unsigned         NUM_KEYS     = 3,
  parameter int unsigned         DEBOUNCE_CYC = 1_000_000,
  parameter int unsigned         REPEAT_DLY   = 25_000_000,
  parameter int unsigned         REPEAT_PER   = 5_000_000,
  parameter logic [NUM_KEYS-1:0] REPEAT_EN    = 3'b110
) (
  input  logic          clk,
  input  logic          rst,
  key_pulse_gen_if.slave kp
);

  localparam int unsigned RPT_MAX = (REPEAT_DLY > REPEAT_PER) ? REPEAT_DLY : REPEAT_PER;
  localparam int unsigned RC_W    = $clog2(RPT_MAX);
  localparam int unsigned DC_W    = $clog2(DEBOUNCE_CYC + 1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    HOLD = 2'd1,
    RPT  = 2'd2
  } rpt_state_e;

  logic [NUM_KEYS-1:0] pulse_n_vec;
  logic [NUM_KEYS-1:0] level_vec;

  genvar gi;
  generate
    for (gi = 0; gi < NUM_KEYS; gi++) begin : g_key
      localparam logic RPT_ON = REPEAT_EN[gi];

      logic            s1_q;
      logic            s2_q;
      logic            st_q;
      logic            pulse_n_q;
      logic [DC_W-1:0] dc_q;
      logic [RC_W-1:0] rc_q;
      rpt_state_e      state_q;

      logic s_pressed;
      logic dc_done;
      logic press_ev;
      logic release_ev;

      // The accepted level flips on the same edge that emits the press pulse.
      assign s_pressed  = ~s2_q;
      assign dc_done    = (s_pressed != st_q) && (dc_q == DC_W'(DEBOUNCE_CYC - 1));
      assign press_ev   = dc_done && !st_q;
      assign release_ev = dc_done && st_q;

      always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
          s1_q      <= 1'b1;
          s2_q      <= 1'b1;
          st_q      <= 1'b0;
          pulse_n_q <= 1'b1;
          dc_q      <= '0;
          rc_q      <= '0;
          state_q   <= IDLE;
        end else begin
          s1_q      <= kp.key_in_n[gi];
          s2_q      <= s1_q;
          pulse_n_q <= 1'b1;

          if (s_pressed == st_q) begin
            dc_q <= '0;
          end else if (dc_done) begin
            st_q <= ~st_q;
            dc_q <= '0;
          end else begin
            dc_q <= dc_q + DC_W'(1);
          end

          if (press_ev) begin
            pulse_n_q <= 1'b0;
          end

          // Release wins over a repeat pulse falling due on the same edge.
          case (state_q)
            IDLE: begin
              if (press_ev && RPT_ON) begin
                state_q <= HOLD;
                rc_q    <= '0;
              end
            end
            HOLD: begin
              if (release_ev) begin
                state_q <= IDLE;
                rc_q    <= '0;
              end else if (rc_q == RC_W'(REPEAT_DLY - 1)) begin
                pulse_n_q <= 1'b0;
                rc_q      <= '0;
                state_q   <= RPT;
              end else begin
                rc_q <= rc_q + RC_W'(1);
              end
            end
            RPT: begin
              if (release_ev) begin
                state_q <= IDLE;
                rc_q    <= '0;
              end else if (rc_q == RC_W'(REPEAT_PER - 1)) begin
                pulse_n_q <= 1'b0;
                rc_q      <= '0;
              end else begin
                rc_q <= rc_q + RC_W'(1);
              end
            end
            default: begin
              state_q <= IDLE;
              rc_q    <= '0;
            end
          endcase
        end
      end

      assign pulse_n_vec[gi] = pulse_n_q;
      assign level_vec[gi]   = st_q;
    end
  endgenerate

  assign kp.key_pulse_n = pulse_n_vec;
  assign kp.key_level   = level_vec;

endmodule

// File: tb/tb_key_pulse_gen.sv
// Directed cycle-by-cycle bench for key_pulse_gen with short debounce and
// repeat periods so every timing edge can be checked exactly.
module tb_key_pulse_gen;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  key_pulse_gen_if #(.NUM_KEYS(3)) kif ();

  key_pulse_gen #(
    .NUM_KEYS    (3),
    .DEBOUNCE_CYC(4),
    .REPEAT_DLY  (10),
    .REPEAT_PER  (3),
    .REPEAT_EN   (3'b110)
  ) dut (
    .clk(clk),
    .rst(rst),
    .kp (kif.slave)
  );

  int errors = 0;
  int checks = 0;

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset;
    rst = 1'b1;
    kif.key_in_n = 3'b111;
    tick();
    tick();
    checks++;
    if (kif.key_pulse_n !== 3'b111) begin
      errors++;
      $display("FAIL reset_pulse got=%b exp=111", kif.key_pulse_n);
    end
    checks++;
    if (kif.key_level !== 3'b000) begin
      errors++;
      $display("FAIL reset_level got=%b exp=000", kif.key_level);
    end
    rst = 1'b0;
    for (int c = 0; c < 8; c++) tick();
    $display("test_reset done");
  endtask

  // Key 0 held for 30 cycles: one pulse at E5, level 5..34, no repeats.
  task automatic test_clean_press;
    logic [2:0] exp_p, exp_l;
    for (int c = 0; c < 45; c++) begin
      kif.key_in_n = (c < 30) ? 3'b110 : 3'b111;
      tick();
      exp_p = 3'b111;
      exp_l = 3'b000;
      if (c == 5) exp_p[0] = 1'b0;
      if (c >= 5 && c < 35) exp_l[0] = 1'b1;
      checks++;
      if (kif.key_pulse_n !== exp_p) begin
        errors++;
        $display("FAIL clean_pulse c=%0d got=%b exp=%b", c, kif.key_pulse_n, exp_p);
      end
      checks++;
      if (kif.key_level !== exp_l) begin
        errors++;
        $display("FAIL clean_level c=%0d got=%b exp=%b", c, kif.key_level, exp_l);
      end
    end
    $display("test_clean_press done");
  endtask

  // Key 1 bounces, then is steady low from edge 7: pulse at edge 12 only.
  task automatic test_bounce;
    logic [2:0] exp_p, exp_l;
    logic       lvl;
    for (int c = 0; c < 30; c++) begin
      lvl = 1'b0;
      if (c == 3 || c == 6 || c >= 15) lvl = 1'b1;
      kif.key_in_n = {1'b1, lvl, 1'b1};
      tick();
      exp_p = 3'b111;
      exp_l = 3'b000;
      if (c == 12) exp_p[1] = 1'b0;
      if (c >= 12 && c < 20) exp_l[1] = 1'b1;
      checks++;
      if (kif.key_pulse_n !== exp_p) begin
        errors++;
        $display("FAIL bounce_pulse c=%0d got=%b exp=%b", c, kif.key_pulse_n, exp_p);
      end
      checks++;
      if (kif.key_level !== exp_l) begin
        errors++;
        $display("FAIL bounce_level c=%0d got=%b exp=%b", c, kif.key_level, exp_l);
      end
    end
    $display("test_bounce done");
  endtask

  // Key 1 held 40 cycles: pulses 5, 15, 18, ... 42; the one due at 45 meets
  // the release edge and must be suppressed.
  task automatic test_repeat;
    logic [2:0] exp_p, exp_l;
    for (int c = 0; c < 60; c++) begin
      kif.key_in_n = (c < 40) ? 3'b101 : 3'b111;
      tick();
      exp_p = 3'b111;
      exp_l = 3'b000;
      if (c == 5 || (c >= 15 && c < 45 && (c - 15) % 3 == 0)) exp_p[1] = 1'b0;
      if (c >= 5 && c < 45) exp_l[1] = 1'b1;
      checks++;
      if (kif.key_pulse_n !== exp_p) begin
        errors++;
        $display("FAIL repeat_pulse c=%0d got=%b exp=%b", c, kif.key_pulse_n, exp_p);
      end
      checks++;
      if (kif.key_level !== exp_l) begin
        errors++;
        $display("FAIL repeat_level c=%0d got=%b exp=%b", c, kif.key_level, exp_l);
      end
    end
    $display("test_repeat done");
  endtask

  // Keys 0 and 2 together: shared pulse at 5, only key 2 repeats.
  task automatic test_simultaneous;
    logic [2:0] exp_p, exp_l;
    for (int c = 0; c < 40; c++) begin
      kif.key_in_n = (c < 25) ? 3'b010 : 3'b111;
      tick();
      exp_p = 3'b111;
      exp_l = 3'b000;
      if (c == 5) exp_p[0] = 1'b0;
      if (c == 5 || (c >= 15 && c < 30 && (c - 15) % 3 == 0)) exp_p[2] = 1'b0;
      if (c >= 5 && c < 30) exp_l = 3'b101;
      checks++;
      if (kif.key_pulse_n !== exp_p) begin
        errors++;
        $display("FAIL simul_pulse c=%0d got=%b exp=%b", c, kif.key_pulse_n, exp_p);
      end
      checks++;
      if (kif.key_level !== exp_l) begin
        errors++;
        $display("FAIL simul_level c=%0d got=%b exp=%b", c, kif.key_level, exp_l);
      end
    end
    $display("test_simultaneous done");
  endtask

  // Reset while key 2 is repeating, key held throughout.
  task automatic test_reset_mid_hold;
    logic [2:0] exp_p, exp_l;
    for (int c = 0; c < 20; c++) begin
      kif.key_in_n = 3'b011;
      tick();
      exp_p = 3'b111;
      if (c == 5 || c == 15 || c == 18) exp_p[2] = 1'b0;
      checks++;
      if (kif.key_pulse_n !== exp_p) begin
        errors++;
        $display("FAIL prerst_pulse c=%0d got=%b exp=%b", c, kif.key_pulse_n, exp_p);
      end
    end
    rst = 1'b1;
    #1;
    for (int r = 0; r < 3; r++) begin
      checks++;
      if (kif.key_pulse_n !== 3'b111) begin
        errors++;
        $display("FAIL rst_pulse r=%0d got=%b exp=111", r, kif.key_pulse_n);
      end
      checks++;
      if (kif.key_level !== 3'b000) begin
        errors++;
        $display("FAIL rst_level r=%0d got=%b exp=000", r, kif.key_level);
      end
      if (r < 2) tick();
    end
    rst = 1'b0;
    for (int c = 0; c < 36; c++) begin
      kif.key_in_n = (c < 21) ? 3'b011 : 3'b111;
      tick();
      exp_p = 3'b111;
      exp_l = 3'b000;
      if (c == 5 || (c >= 15 && c < 26 && (c - 15) % 3 == 0)) exp_p[2] = 1'b0;
      if (c >= 5 && c < 26) exp_l[2] = 1'b1;
      checks++;
      if (kif.key_pulse_n !== exp_p) begin
        errors++;
        $display("FAIL postrst_pulse c=%0d got=%b exp=%b", c, kif.key_pulse_n, exp_p);
      end
      checks++;
      if (kif.key_level !== exp_l) begin
        errors++;
        $display("FAIL postrst_level c=%0d got=%b exp=%b", c, kif.key_level, exp_l);
      end
    end
    $display("test_reset_mid_hold done");
  endtask

  // One-cycle glitches every third cycle on all keys must be ignored.
  task automatic test_glitch;
    for (int c = 0; c < 30; c++) begin
      kif.key_in_n = (c % 3 == 0) ? 3'b000 : 3'b111;
      tick();
      checks++;
      if (kif.key_pulse_n !== 3'b111) begin
        errors++;
        $display("FAIL glitch_pulse c=%0d got=%b exp=111", c, kif.key_pulse_n);
      end
      checks++;
      if (kif.key_level !== 3'b000) begin
        errors++;
        $display("FAIL glitch_level c=%0d got=%b exp=000", c, kif.key_level);
      end
    end
    kif.key_in_n = 3'b111;
    $display("test_glitch done");
  endtask

  initial begin
    test_reset();
    test_clean_press();
    test_bounce();
    test_repeat();
    test_simultaneous();
    test_reset_mid_hold();
    test_glitch();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
